// File: rtl/swap_datapath.sv
// ============================================================================
// Module   : swap_datapath
// Purpose  : A/B register swap through T driven by an upstream w/sel sequence,
//            with host loads, done pulse, swap counter and sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module swap_datapath #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               w,
  input  logic [1:0]         sel,
  input  logic [WIDTH-1:0]   din,
  input  logic               load_a,
  input  logic               load_b,
  input  logic               clr_err,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] swap_count,
  output logic               load_err,
  output logic               seq_err
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_got1 = 2'd1;
  localparam logic [1:0] c_got2 = 2'd2;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_t;
  logic [1:0]         r_state;
  logic               r_done;
  logic [COUNT_W-1:0] r_count;
  logic               r_load_err;
  logic               r_seq_err;

  logic [1:0]         w_next_state;
  logic               w_seq_set;
  logic               w_complete;
  logic               w_load_set;

  // Sequence tracker: sel=1 always (re)starts a swap, any other break returns to idle.
  always_comb begin
    w_next_state = r_state;
    w_seq_set    = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      c_idle: begin
        if (w) begin
          if (sel == 2'd1) w_next_state = c_got1;
          else             w_seq_set    = 1'b1;
        end
      end
      c_got1: begin
        if (w && sel == 2'd2) begin
          w_next_state = c_got2;
        end else begin
          w_seq_set    = 1'b1;
          w_next_state = (w && sel == 2'd1) ? c_got1 : c_idle;
        end
      end
      c_got2: begin
        if (w && sel == 2'd3) begin
          w_next_state = c_idle;
          w_complete   = 1'b1;
        end else begin
          w_seq_set    = 1'b1;
          w_next_state = (w && sel == 2'd1) ? c_got1 : c_idle;
        end
      end
      default: w_next_state = c_idle;
    endcase
  end

  assign w_load_set = w & (load_a | load_b);

  // Swap steps always follow w/sel; host loads only land while w is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a <= '0;
      r_b <= '0;
      r_t <= '0;
    end else if (w) begin
      case (sel)
        2'd1:    r_t <= r_a;
        2'd2:    r_a <= r_b;
        2'd3:    r_b <= r_t;
        default: ;
      endcase
    end else begin
      if (load_a) r_a <= din;
      if (load_b) r_b <= din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= c_idle;
      r_done     <= 1'b0;
      r_count    <= '0;
      r_load_err <= 1'b0;
      r_seq_err  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_complete;
      if (w_complete) r_count <= r_count + COUNT_W'(1);
      // Set takes priority over a same-cycle clear.
      if (w_load_set)   r_load_err <= 1'b1;
      else if (clr_err) r_load_err <= 1'b0;
      if (w_seq_set)    r_seq_err  <= 1'b1;
      else if (clr_err) r_seq_err  <= 1'b0;
    end
  end

  assign a_out      = r_a;
  assign b_out      = r_b;
  assign busy       = w | (r_state != c_idle);
  assign done       = r_done;
  assign swap_count = r_count;
  assign load_err   = r_load_err;
  assign seq_err    = r_seq_err;

endmodule

`default_nettype wire
